// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Jump target = {PC+4 upper nibble, 26-bit index, 2 zero bits}
    localparam int JUMP_HI_W  = 4;
    localparam int JUMP_IDX_W = 26;
    localparam int JUMP_LO_W  = 2;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } npc_sel_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select (JR > J > BR > sequential), target alignment and redirect flag.
module next_pc_mux
    import fetch_stage_pkg::*;
(
    input  logic [31:0]           i_pc,
    input  logic [31:0]           i_ifid_pcplus4,
    input  logic                  i_branch_taken,
    input  logic [31:0]           i_branch_target,
    input  logic                  i_jump_taken,
    input  logic [JUMP_IDX_W-1:0] i_jump_index,
    input  logic                  i_jump_reg,
    input  logic [31:0]           i_jump_reg_target,
    output logic [31:0]           o_pc_plus4,
    output logic [31:0]           o_next_pc,
    output npc_sel_e              o_sel,
    output logic                  o_redirect
);

    logic [31:0] w_jump_target;
    logic [31:0] w_raw_target;

    assign o_pc_plus4    = i_pc + 32'd4;
    assign w_jump_target = {i_ifid_pcplus4[31:32-JUMP_HI_W], i_jump_index, {JUMP_LO_W{1'b0}}};
    assign o_redirect    = i_jump_reg | i_jump_taken | i_branch_taken;

    always_comb begin
        o_sel        = SEL_SEQ;
        w_raw_target = o_pc_plus4;
        if (i_jump_reg) begin
            o_sel        = SEL_JR;
            w_raw_target = i_jump_reg_target;
        end else if (i_jump_taken) begin
            o_sel        = SEL_J;
            w_raw_target = w_jump_target;
        end else if (i_branch_taken) begin
            o_sel        = SEL_BR;
            w_raw_target = i_branch_target;
        end
    end

    // Control-transfer targets are word-aligned by dropping the low two bits.
    assign o_next_pc = {w_raw_target[31:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and sticky fetch fault.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the redirect-cycle instruction instead of squashing it.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        FetchFault
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pcplus4;
    logic        r_ifid_valid;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    npc_sel_e    w_sel;
    logic        w_redirect;
    logic        w_in_range;
    logic        w_capture;

    next_pc_mux u_next_pc_mux (
        .i_pc              (r_pc),
        .i_ifid_pcplus4    (r_ifid_pcplus4),
        .i_branch_taken    (BranchTaken),
        .i_branch_target   (BranchTarget),
        .i_jump_taken      (JumpTaken),
        .i_jump_index      (JumpIndex),
        .i_jump_reg        (JumpReg),
        .i_jump_reg_target (JumpRegTarget),
        .o_pc_plus4        (w_pc_plus4),
        .o_next_pc         (w_next_pc),
        .o_sel             (w_sel),
        .o_redirect        (w_redirect)
    );

    assign w_in_range = (r_pc < IMEM_BYTES);

`ifdef BRANCH_DELAY_SLOT_EN
    // The delay slot is captured like any other fetch unless the pipeline is stalled.
    assign w_capture = ~Stall;
`else
    assign w_capture = ~Stall & ~w_redirect;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc           <= RESET_PC;
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pcplus4 <= 32'd0;
            r_ifid_valid   <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            if (w_redirect || !Stall) begin
                r_pc <= w_next_pc;
            end
            if (w_capture) begin
                r_ifid_pcplus4 <= w_pc_plus4;
                if (w_in_range) begin
                    r_ifid_instr <= Instruction;
                    r_ifid_valid <= 1'b1;
                end else begin
                    r_ifid_instr <= NOP_INSTR;
                    r_ifid_valid <= 1'b0;
                    r_fault      <= 1'b1;
                end
            end
`ifndef BRANCH_DELAY_SLOT_EN
            else if (w_redirect) begin
                // Squash: PC+4 is left holding since a bubble never uses it.
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end
`endif
        end
    end

    assign Address          = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PCPlus4     = r_ifid_pcplus4;
    assign IFID_Valid       = r_ifid_valid;
    assign FetchFault       = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic vs a cycle model.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        FetchFault;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;

    fetch_stage dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .JumpTaken        (JumpTaken),
        .JumpIndex        (JumpIndex),
        .JumpReg          (JumpReg),
        .JumpRegTarget    (JumpRegTarget),
        .Address          (Address),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchFault       (FetchFault)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents: 32'h2008_0005 at address 0, distinct word elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h2008_0005 + a;
    endfunction

    always_comb Instruction = imem(Address);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".addr"},  Address,          m_pc);
        check_eq({tag, ".instr"}, IFID_Instruction, m_instr);
        check_eq({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, m_valid});
        check_eq({tag, ".fault"}, {31'd0, FetchFault}, {31'd0, m_fault});
        if (m_valid) check_eq({tag, ".pc4"}, IFID_PCPlus4, m_pc4);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    // One fetch into the IF/ID model: fault and bubble outside 128 words.
    task automatic model_capture();
        m_pc4 = m_pc + 32'd4;
        if (m_pc < 32'd512) begin
            m_instr = imem(m_pc);
            m_valid = 1'b1;
        end else begin
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_fault = 1'b1;
        end
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] brt,
                              input logic j, input logic [25:0] ji,
                              input logic jr, input logic [31:0] jrt);
        logic [31:0] tgt;
        if (jr)      tgt = jrt;
        else if (j)  tgt = {m_pc4[31:28], ji, 2'b00};
        else         tgt = brt;
        tgt = tgt & 32'hFFFF_FFFC;
        if (jr || j || br) begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (!st) model_capture();
`else
            m_instr = 32'h0;
            m_valid = 1'b0;
`endif
            m_pc = tgt;
        end else if (!st) begin
            model_capture();
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Driver: apply controls for one cycle, predict, clock, compare.
    task automatic step(input string tag, input logic st, input logic br, input logic [31:0] brt,
                        input logic j, input logic [25:0] ji,
                        input logic jr, input logic [31:0] jrt);
        Stall = st; BranchTaken = br; BranchTarget = brt;
        JumpTaken = j; JumpIndex = ji; JumpReg = jr; JumpRegTarget = jrt;
        model_step(st, br, brt, j, ji, jr, jrt);
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        Rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        Stall = 0; BranchTaken = 0; BranchTarget = 0; JumpTaken = 0;
        JumpIndex = 0; JumpReg = 0; JumpRegTarget = 0;
        Rst = 1'b0;
        model_reset();
        #12;
        do_reset("reset");
        check_eq("reset.pc4", IFID_PCPlus4, 32'h0);

        // free run
        for (int i = 0; i < 2; i++) idle("run");
        check_eq("run.addr8", Address, 32'h8);
        // stall two cycles at PC=8
        step("stall", 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        step("stall", 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        idle("resume");
        check_eq("resume.addr", Address, 32'hC);
        idle("run");
        // branch with stall
        step("br_stall", 1'b1, 1'b1, 32'h24, 1'b0, 26'h0, 1'b0, 32'h0);
        check_eq("br_stall.addr", Address, 32'h24);
        for (int i = 0; i < 3; i++) idle("run");
        // all three redirects: JR wins, aligned
        step("prio", 1'b0, 1'b1, 32'h100, 1'b1, 26'h9, 1'b1, 32'h43);
        check_eq("prio.addr", Address, 32'h40);
        idle("run");

        // free run past end of memory
        for (int i = 0; i < 200 && m_pc < 32'h208; i++) idle("runout");
        check_eq("runout.fault", {31'd0, FetchFault}, 32'd1);
        check_eq("runout.valid", {31'd0, IFID_Valid}, 32'd0);
        // jump to 0 (IFID_PCPlus4 upper nibble is 0)
        step("recover", 1'b0, 1'b0, 32'h0, 1'b1, 26'h0, 1'b0, 32'h0);
        check_eq("recover.addr", Address, 32'h0);
        for (int i = 0; i < 3; i++) idle("recover_run");
        check_eq("recover.fault", {31'd0, FetchFault}, 32'd1);

        // asynchronous reset pulse mid-cycle
        #3;
        do_reset("async_rst");
        for (int i = 0; i < 2; i++) idle("post_rst");

        // jump using upper PC nibble
        step("jr_far", 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000_000C);
        idle("far_fetch");
        check_eq("far_fetch.pc4", IFID_PCPlus4, 32'h1000_0010);
        step("j_far", 1'b0, 1'b0, 32'h0, 1'b1, 26'h9, 1'b0, 32'h0);
        check_eq("j_far.addr", Address, 32'h1000_0024);

        @(negedge Clk);
        do_reset("reset2");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        st, br, j, jr;
            logic [31:0] brt, jrt;
            logic [25:0] ji;
            st  = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 10);
            j   = ($urandom_range(0, 99) < 7);
            jr  = ($urandom_range(0, 99) < 5);
            brt = 32'($urandom_range(0, 150)) * 32'd4 + 32'($urandom_range(0, 3));
            jrt = 32'($urandom_range(0, 150)) * 32'd4 + 32'($urandom_range(0, 3));
            ji  = 26'($urandom_range(0, 140));
            if ($urandom_range(0, 99) == 0) begin
                @(negedge Clk);
                do_reset("rand_rst");
            end
            step("rand", st, br, brt, j, ji, jr, jrt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
